// File: rtl/pulse_shaper.sv
// Turns single-cycle request strobes into registered pulses with a guaranteed
// minimum active width and inactive gap; overlapping requests are queued.
module pulse_shaper #(
   parameter int   C_PULSE_WIDTH     = 16,
   parameter int   C_GAP_WIDTH       = 16,
   parameter logic C_OUTPUT_POLARITY = 1'b0,
   parameter int   C_PENDING_BITS    = 4
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic                      trig_in,
   input  logic                      ovf_clr,
   output logic                      signal_out,
   output logic                      busy,
   output logic [C_PENDING_BITS-1:0] pending,
   output logic                      ovf
);

   localparam int C_TMAX = (C_PULSE_WIDTH > C_GAP_WIDTH) ? C_PULSE_WIDTH : C_GAP_WIDTH;
   localparam int TW     = $clog2(C_TMAX + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_GAP    = 2'd2;

   localparam logic [TW-1:0]             PW_LOAD  = TW'(C_PULSE_WIDTH - 1);
   localparam logic [TW-1:0]             GAP_LOAD = TW'(C_GAP_WIDTH - 1);
   localparam logic [C_PENDING_BITS-1:0] PEND_MAX = '1;

   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic          timer_zero;
   logic          gap_end;
   logic          enq;
   logic          deq;
   logic          drop;

   assign timer_zero = (timer == '0);
   assign gap_end    = (state == S_GAP) && timer_zero;
   // A strobe on the final gap cycle restarts the pulse directly; with a
   // non-empty queue it stands in for the dequeued request (net unchanged).
   assign enq  = trig_in && ((state == S_ACTIVE) || ((state == S_GAP) && !timer_zero));
   assign deq  = gap_end && (pending != '0) && !trig_in;
   assign drop = enq && (pending == PEND_MAX);
   assign busy = (state != S_IDLE) || (pending != '0);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         signal_out <= ~C_OUTPUT_POLARITY;
      end else begin
         case (state)
            S_IDLE: begin
               if (trig_in) begin
                  state      <= S_ACTIVE;
                  timer      <= PW_LOAD;
                  signal_out <= C_OUTPUT_POLARITY;
               end
            end
            S_ACTIVE: begin
               if (timer_zero) begin
                  state      <= S_GAP;
                  timer      <= GAP_LOAD;
                  signal_out <= ~C_OUTPUT_POLARITY;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_GAP: begin
               if (!timer_zero) begin
                  timer <= timer - 1'b1;
               end else if ((pending != '0) || trig_in) begin
                  state      <= S_ACTIVE;
                  timer      <= PW_LOAD;
                  signal_out <= C_OUTPUT_POLARITY;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state      <= S_IDLE;
               timer      <= '0;
               signal_out <= ~C_OUTPUT_POLARITY;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pending <= '0;
         ovf     <= 1'b0;
      end else begin
         if (enq && !drop)
            pending <= pending + 1'b1;
         else if (deq)
            pending <= pending - 1'b1;
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pulse_shaper.sv
// Directed bench for pulse_shaper: three parameterizations share one stimulus
// stream; each test resets them and checks the relevant instance.
module tb_pulse_shaper;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       trig_in = 1'b0;
   logic       ovf_clr = 1'b0;

   logic       out_a, busy_a, ovf_a;
   logic [3:0] pend_a;
   logic       out_b, busy_b, ovf_b;
   logic [1:0] pend_b;
   logic       out_c, busy_c, ovf_c;
   logic [3:0] pend_c;

   int total = 0;
   int bad   = 0;
   int cnt_b = 0;
   logic prev_b = 1'b0;

   always #5 sys_clk = ~sys_clk;

   pulse_shaper #(.C_PULSE_WIDTH(4), .C_GAP_WIDTH(3), .C_OUTPUT_POLARITY(1'b1), .C_PENDING_BITS(4)) u_a (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .trig_in(trig_in), .ovf_clr(ovf_clr),
      .signal_out(out_a), .busy(busy_a), .pending(pend_a), .ovf(ovf_a));

   pulse_shaper #(.C_PULSE_WIDTH(4), .C_GAP_WIDTH(3), .C_OUTPUT_POLARITY(1'b1), .C_PENDING_BITS(2)) u_b (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .trig_in(trig_in), .ovf_clr(ovf_clr),
      .signal_out(out_b), .busy(busy_b), .pending(pend_b), .ovf(ovf_b));

   pulse_shaper #(.C_PULSE_WIDTH(1), .C_GAP_WIDTH(1), .C_OUTPUT_POLARITY(1'b0), .C_PENDING_BITS(4)) u_c (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .trig_in(trig_in), .ovf_clr(ovf_clr),
      .signal_out(out_c), .busy(busy_c), .pending(pend_c), .ovf(ovf_c));

   typedef struct {
      logic       trig;
      logic       out;
      logic       busy;
      logic [3:0] pend;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // inputs change on the falling edge, outputs are sampled 1ns after the rising edge
   task automatic cyc(input logic t, input logic c);
      @(negedge sys_clk);
      trig_in = t;
      ovf_clr = c;
      @(posedge sys_clk);
      #1;
      if (out_b && !prev_b) cnt_b++;
      prev_b = out_b;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst = 1'b1;
      trig_in = 1'b0;
      ovf_clr = 1'b0;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      cnt_b  = 0;
      prev_b = out_b;
   endtask

   task automatic add(input logic t, input logic o, input logic b, input logic [3:0] p, input int n);
      for (int i = 0; i < n; i++) vq.push_back('{t, o, b, p});
   endtask

   initial begin
      logic [8:0] exp_c;

      // reset state while reset is held
      #12;
      chk("rst_out_a", out_a, 0);
      chk("rst_out_c", out_c, 1);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_pend_a", pend_a, 0);
      chk("rst_ovf_a", ovf_a, 0);
      do_reset();

      // single request: 4 high, 3 low busy, then idle
      add(1, 1, 1, 0, 1);
      add(0, 1, 1, 0, 3);
      add(0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 1);
      // burst of three: period 7, pending 2 -> 1 -> 0, 21 busy cycles
      add(1, 1, 1, 0, 1);
      add(1, 1, 1, 1, 1);
      add(1, 1, 1, 2, 1);
      add(0, 1, 1, 2, 1);
      add(0, 0, 1, 2, 3);
      add(0, 1, 1, 1, 4);
      add(0, 0, 1, 1, 3);
      add(0, 1, 1, 0, 4);
      add(0, 0, 1, 0, 3);
      add(0, 0, 0, 0, 1);

      foreach (vq[i]) begin
         cyc(vq[i].trig, 1'b0);
         chk($sformatf("vec%0d_out", i), out_a, vq[i].out);
         chk($sformatf("vec%0d_busy", i), busy_a, vq[i].busy);
         chk($sformatf("vec%0d_pend", i), pend_a, vq[i].pend);
      end

      // overflow with 2-bit pending counter
      do_reset();
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
      chk("ovf_pend_sat", pend_b, 3);
      chk("ovf_set", ovf_b, 1);
      for (int i = 0; i < 60 && busy_b; i++) cyc(1'b0, 1'b0);
      chk("ovf_drain", busy_b, 0);
      chk("ovf_pulses", cnt_b, 4);
      chk("ovf_sticky", ovf_b, 1);
      cyc(1'b0, 1'b1);
      chk("ovf_clr", ovf_b, 0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
      chk("ovf_refill", pend_b, 3);
      chk("ovf_refill_flag", ovf_b, 0);
      cyc(1'b1, 1'b1);
      chk("ovf_set_wins", ovf_b, 1);
      chk("ovf_set_wins_pend", pend_b, 3);

      // trigger on the final gap cycle
      do_reset();
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
      chk("gapend0_pre_out", out_a, 0);
      cyc(1'b1, 1'b0);
      chk("gapend0_out", out_a, 1);
      chk("gapend0_pend", pend_a, 0);
      cyc(1'b1, 1'b0);
      chk("gapend1_queue", pend_a, 1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
      chk("gapend1_pre_out", out_a, 0);
      cyc(1'b1, 1'b0);
      chk("gapend1_out", out_a, 1);
      chk("gapend1_pend", pend_a, 1);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
      chk("gapend1_gap", out_a, 0);
      cyc(1'b0, 1'b0);
      chk("gapend1_deq_out", out_a, 1);
      chk("gapend1_deq_pend", pend_a, 0);

      // asynchronous reset mid-pulse
      do_reset();
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("arst_pre_pend", pend_a, 2);
      chk("arst_pre_out", out_a, 1);
      #2 sys_rst = 1'b1;
      #1;
      chk("arst_out", out_a, 0);
      chk("arst_pend", pend_a, 0);
      chk("arst_busy", busy_a, 0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      cyc(1'b1, 1'b0);
      chk("arst_after_out", out_a, 1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
      chk("arst_after_hold", out_a, 1);
      cyc(1'b0, 1'b0);
      chk("arst_after_low", out_a, 0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
      chk("arst_after_idle", busy_a, 0);

      // active-low, width-1 pulses and gaps
      do_reset();
      exp_c = 9'b1_1010_1010;
      for (int i = 0; i < 9; i++) begin
         cyc(i < 4, 1'b0);
         chk($sformatf("w1_out%0d", i), out_c, exp_c[i]);
      end
      chk("w1_idle", busy_c, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pulse_shaper.md
Name: pulse_shaper

Overview:
- Output-side counterpart of the input de-jitter filter: turns single-cycle event strobes from internal logic into clean, registered, glitch-free output pulses.
- Each output pulse has a guaranteed minimum asserted width and a guaranteed minimum deasserted gap, so the downstream receiver's hold/debounce filter always sees a valid level.
- Used for DAC control lines (LDAC, RESET-style strobes) and board-level indicator/handshake outputs.
- Strobes that arrive while a pulse is in progress are queued in a saturating pending counter.

Parameters:
- C_PULSE_WIDTH, 16: asserted width in sys_clk cycles; must be >= 1.
- C_GAP_WIDTH, 16: minimum deasserted gap after every pulse, in sys_clk cycles; must be >= 1.
- C_OUTPUT_POLARITY, 1'b0: active level of signal_out.
- C_PENDING_BITS, 4: width of the pending-request counter. Maximum queued requests = 2^C_PENDING_BITS - 1.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  reset, asynchronous and active-high.
- trig_in  in  1  request strobe; each cycle it is high counts as one request.
- ovf_clr  in  1  clears the sticky overflow flag.
- signal_out  out  1  shaped output, registered.
- busy  out  1  high when state != IDLE or pending != 0.
- pending  out  C_PENDING_BITS  number of queued requests.
- ovf  out  1  sticky flag: a request was dropped.

Behaviour:
- Reset (asynchronous, while sys_rst is high):
  - signal_out = !C_OUTPUT_POLARITY, state = IDLE.
  - Timer = 0, pending = 0, ovf = 0, busy = 0.
  - Reset mid-pulse truncates the pulse immediately and discards all queued requests.
- FSM states: IDLE, ACTIVE, GAP.
- Timer: down-counter of width $clog2(max(C_PULSE_WIDTH, C_GAP_WIDTH)+1).
- IDLE:
  - trig_in sampled high at edge k → at edge k: state = ACTIVE, signal_out = C_OUTPUT_POLARITY, timer = C_PULSE_WIDTH-1.
  - Latency from trig_in to signal_out is one registered cycle.
- ACTIVE:
  - Timer decrements each edge.
  - At timer == 0: state = GAP, signal_out inactive, timer = C_GAP_WIDTH-1.
  - The active level therefore lasts exactly C_PULSE_WIDTH cycles.
- GAP:
  - Timer decrements each edge. At timer == 0:
    - pending > 0: state = ACTIVE, pulse restarts, pending decrements. If trig_in is high in the same cycle, pending is unchanged (net).
    - pending == 0 and trig_in high: state = ACTIVE directly; the request is not queued.
    - otherwise: state = IDLE.
- Queuing:
  - trig_in high in ACTIVE, or in GAP before its final cycle, increments pending.
  - pending saturates at its maximum. A request arriving at saturation with no simultaneous dequeue is dropped and ovf is set.
- ovf:
  - Sticky; cleared by ovf_clr.
  - If ovf_clr and a new drop occur in the same cycle, the set wins.
- Throughput:
  - Back-to-back pulse period = C_PULSE_WIDTH + C_GAP_WIDTH cycles.
  - The output never shows an active segment shorter than C_PULSE_WIDTH or an inactive segment shorter than C_GAP_WIDTH between pulses.
- All outputs are registered except busy, which is combinational from registered state.

Test Plan:
1. Single request, PW=4, GAP=3, POL=1: trig_in one cycle from IDLE → signal_out high exactly 4 cycles starting the edge after trig. Then low, busy high for 3 more cycles, then busy=0 and state IDLE.
2. Burst, PW=4, GAP=3, POL=1: 3 consecutive trig cycles → first trig launches the pulse and the remaining 2 queue (pending=2). Result is 3 pulses of 4 high / 3 low, period 7. Pending counts 2→1→0 at each GAP end; total busy span 21 cycles.
3. Overflow, PEND_BITS=2: 5 trig cycles while ACTIVE → pending saturates at 3, ovf=1, exactly 4 pulses emitted. Then ovf_clr → ovf=0. ovf_clr together with a new drop → ovf stays 1.
4. Boundary at GAP end:
   - trig on the final GAP cycle with pending=0 → next pulse starts with no extra idle cycle and pending stays 0.
   - Same with pending=1 → pending stays 1 and a pulse starts.
5. Asynchronous reset mid-ACTIVE with pending=2 → signal_out inactive immediately (before the next edge), pending=0, busy=0. A trig after reset release produces a normal single pulse.
6. Polarity and width-1 case, POL=0, PW=1, GAP=1: continuous trig for 4 cycles → signal_out idles high and alternates low/high once per cycle. Pulses are 1 cycle low, 1 cycle high, with no merged segments.
